// File: rtl/bank_arbiter.sv
// bank_arbiter: round-robin arbiter that lets REQ_N requesters share one memory bank.
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   req / req_write /       per-requester request level, direction (1=write),
//   req_pad                 and pad enable
//   req_row/col/wdata       flattened per-requester address and write data (requester i at slice i)
//   done, err, rdata        one-cycle completion pulse, timeout flag and read data (valid with done)
//   grant                   one-hot current owner, 0 when idle
//   mem_*                   bank command/data outputs, mem_ack/mem_rdata from the bank
//
// Transaction: IDLE picks a winner and latches its fields, ISSUE drives the bank until ack
// or TIMEOUT cycles, DONE pulses done for one cycle and advances the round-robin pointer.

`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 8
`endif
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 8
`endif

module bank_arbiter #(
  parameter int REQ_N   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [REQ_N-1:0]                  req,
  input  logic [REQ_N-1:0]                  req_write,
  input  logic [REQ_N-1:0]                  req_pad,
  input  logic [REQ_N*`BANK_ADDR_WIDTH-1:0] req_row,
  input  logic [REQ_N*`COL_ADDR_WIDTH-1:0]  req_col,
  input  logic [REQ_N*`TX_DATA_WIDTH-1:0]   req_wdata,
  output logic [REQ_N-1:0]                  done,
  output logic [`TX_DATA_WIDTH-1:0]         rdata,
  output logic                              err,
  output logic [REQ_N-1:0]                  grant,
  output logic                              mem_write_en,
  output logic                              mem_read_en,
  output logic                              mem_pad_en,
  output logic [`BANK_ADDR_WIDTH-1:0]       mem_row,
  output logic [`COL_ADDR_WIDTH-1:0]        mem_col,
  output logic [`TX_DATA_WIDTH-1:0]         mem_wdata,
  input  logic                              mem_ack,
  input  logic [`TX_DATA_WIDTH-1:0]         mem_rdata
);

  localparam int RW    = `BANK_ADDR_WIDTH;
  localparam int CW    = `COL_ADDR_WIDTH;
  localparam int DW    = `TX_DATA_WIDTH;
  localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [REQ_N-1:0] ONE = REQ_N'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   winner_q, winner_d;
  logic [REQ_N-1:0]   grant_q, grant_d;
  logic               wr_q, wr_d;
  logic               pad_q, pad_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [DW-1:0]      rdata_q, rdata_d;

  logic [RW-1:0] row_arr   [REQ_N];
  logic [CW-1:0] col_arr   [REQ_N];
  logic [DW-1:0] wdata_arr [REQ_N];

  for (genvar g = 0; g < REQ_N; g++) begin : g_unpack
    assign row_arr[g]   = req_row[g*RW +: RW];
    assign col_arr[g]   = req_col[g*CW +: CW];
    assign wdata_arr[g] = req_wdata[g*DW +: DW];
  end

  // First requesting index at or after ptr, wrapping.
  logic [PTR_W-1:0] pick_idx;
  logic             pick_found;

  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < REQ_N; k++) begin
      if (!pick_found && req[PTR_W'((int'(ptr_q) + k) % REQ_N)]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'((int'(ptr_q) + k) % REQ_N);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    winner_d     = winner_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    pad_d        = pad_q;
    row_d        = row_q;
    col_d        = col_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    mem_pad_en   = 1'b0;
    done         = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          winner_d = pick_idx;
          grant_d  = ONE << pick_idx;
          wr_d     = req_write[pick_idx];
          pad_d    = req_pad[pick_idx];
          row_d    = row_arr[pick_idx];
          col_d    = col_arr[pick_idx];
          wdata_d  = wdata_arr[pick_idx];
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        mem_write_en = wr_q;
        mem_read_en  = !wr_q;
        mem_pad_en   = pad_q;
        // cnt_q holds completed ISSUE cycles; this is cycle cnt_q+1. Ack beats timeout.
        if (mem_ack) begin
          if (!wr_q) rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        done    = grant_q;
        grant_d = '0;
        cnt_d   = '0;
        ptr_d   = (winner_q == PTR_W'(REQ_N - 1)) ? '0 : winner_q + PTR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      grant_q  <= '0;
      wr_q     <= 1'b0;
      pad_q    <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      pad_q    <= pad_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // err is only meaningful alongside the done pulse.
  assign err       = (state_q == DONE) && err_q;
  assign grant     = grant_q;
  assign rdata     = rdata_q;
  assign mem_row   = row_q;
  assign mem_col   = col_q;
  assign mem_wdata = wdata_q;

endmodule
